// File: rtl/sw_enable_conditioner_pkg.sv
// Shared types and defaults for the switch enable conditioner and related
// board-switch logic.
package sw_enable_conditioner_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'b00,
      S_RISE_WAIT = 2'b01,
      S_HIGH      = 2'b10,
      S_FALL_WAIT = 2'b11
   } sw_state_t;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 500000;

   // States in which the debounced switch level is considered high.
   function automatic logic is_high_side(input sw_state_t s);
      return (s == S_HIGH) || (s == S_FALL_WAIT);
   endfunction

endpackage

// File: rtl/sw_enable_conditioner_if.sv
// Switch-side signal bundle: raw pin and mode in, conditioned enable and
// press/release strobes out.
interface sw_enable_conditioner_if;

   logic SW_raw;
   logic Toggle_Mode;
   logic Enable_SW_0;
   logic Press;
   logic Release;

   modport master (
      output SW_raw,
      output Toggle_Mode,
      input  Enable_SW_0,
      input  Press,
      input  Release
   );

   modport slave (
      input  SW_raw,
      input  Toggle_Mode,
      output Enable_SW_0,
      output Press,
      output Release
   );

endinterface

// File: rtl/sw_enable_conditioner_sync.sv
// Parameterized N-flop metastability synchronizer with asynchronous reset,
// reusable for any asynchronous board switch.
module sw_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/sw_enable_conditioner.sv
// Debounces a raw switch into a registered PWM enable (level or toggle mode)
// with one-cycle press/release strobes.
module sw_enable_conditioner
   import sw_enable_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                      sysclk,
   input  logic                      rst,
   sw_enable_conditioner_if.slave    bus
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             w_sw_s;
   sw_state_t        r_state;
   sw_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_press;
   logic             w_press_nxt;
   logic             r_release;
   logic             w_release_nxt;
   logic             r_tog;
   logic             w_tog_nxt;
   logic             r_en;
   logic             w_en_nxt;

   sw_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (sysclk),
      .rst (rst),
      .i_d (bus.SW_raw),
      .o_q (w_sw_s)
   );

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_state   <= S_LOW;
         r_cnt     <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_tog     <= 1'b0;
         r_en      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
         r_tog     <= w_tog_nxt;
         r_en      <= w_en_nxt;
      end
   end

   // The counter holds the number of consecutive samples seen so far in a
   // wait state; the D-th agreeing sample (count == D-1) is the acceptance.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = '0;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
         S_LOW: begin
            if (w_sw_s) begin
               w_state_nxt = S_RISE_WAIT;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         S_RISE_WAIT: begin
            if (!w_sw_s) begin
               w_state_nxt = S_LOW;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_HIGH;
               w_press_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_HIGH: begin
            if (!w_sw_s) begin
               w_state_nxt = S_FALL_WAIT;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         S_FALL_WAIT: begin
            if (w_sw_s) begin
               w_state_nxt = S_HIGH;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt   = S_LOW;
               w_release_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_LOW;
         end
      endcase
      // Enable follows whichever source the current mode selects, so a mode
      // change takes effect on the next edge without any strobe.
      w_tog_nxt = r_tog ^ w_press_nxt;
      w_en_nxt  = bus.Toggle_Mode ? w_tog_nxt : is_high_side(w_state_nxt);
   end

   assign bus.Enable_SW_0 = r_en;
   assign bus.Press       = r_press;
   assign bus.Release     = r_release;

endmodule

// File: tb/tb_sw_enable_conditioner.sv
// Self-checking bench for sw_enable_conditioner: vector table, directed corner
// sequences and randomized switch activity against a sample-window model.
module tb_sw_enable_conditioner;

   localparam int SYNC = 2;
   localparam int DEB  = 8;
   localparam int LAT  = SYNC + DEB;

   logic sysclk = 1'b0;
   logic rst;

   sw_enable_conditioner_if u_if();

   sw_enable_conditioner #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .sysclk (sysclk),
      .rst    (rst),
      .bus    (u_if)
   );

   always #5 sysclk = ~sysclk;

   int checks = 0;
   int errors = 0;
   int ecnt = 0;
   int last_press_edge = -1;
   int n_press = 0;
   int n_rel = 0;

   // Reference: raw history delayed by the synchronizer depth, then a window
   // of the last DEB synced samples; a full window disagreeing with the
   // debounced value flips it.
   bit m_hist[$];
   bit m_win[$];
   bit m_deb, m_tog, m_press, m_rel, m_en;

   typedef struct {
      bit raw;
      bit mode;
      bit press;
      bit rel;
      bit en;
   } vec_t;

   vec_t tbl[24];

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %b expected %b", name, ecnt, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
      m_win.delete();
      m_deb = 1'b0;
      m_tog = 1'b0;
      m_press = 1'b0;
      m_rel = 1'b0;
      m_en = 1'b0;
   endtask

   task automatic model_edge(input bit raw, input bit mode);
      bit sws;
      bit all_diff;
      m_hist.push_back(raw);
      sws = m_hist.pop_front();
      m_win.push_back(sws);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      m_press = 1'b0;
      m_rel = 1'b0;
      if (m_win.size() == DEB) begin
         all_diff = 1'b1;
         foreach (m_win[i]) if (m_win[i] == m_deb) all_diff = 1'b0;
         if (all_diff) begin
            m_deb = !m_deb;
            if (m_deb) m_press = 1'b1;
            else m_rel = 1'b1;
            m_win.delete();
         end
      end
      if (m_press) m_tog = !m_tog;
      m_en = mode ? m_tog : m_deb;
   endtask

   task automatic record_strobes();
      if (u_if.Press === 1'b1) begin
         last_press_edge = ecnt;
         n_press++;
      end
      if (u_if.Release === 1'b1) n_rel++;
   endtask

   task automatic step(input bit raw, input bit mode);
      u_if.SW_raw = raw;
      u_if.Toggle_Mode = mode;
      @(posedge sysclk);
      ecnt++;
      model_edge(raw, mode);
      #1;
      check("press", u_if.Press, m_press);
      check("release", u_if.Release, m_rel);
      check("enable", u_if.Enable_SW_0, m_en);
      record_strobes();
   endtask

   task automatic hold_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_enable", u_if.Enable_SW_0, 1'b0);
      check("rst_press", u_if.Press, 1'b0);
      check("rst_release", u_if.Release, 1'b0);
      @(negedge sysclk);
      @(negedge sysclk);
      rst = 1'b0;
   endtask

   // Short asynchronous pulse placed between clock edges.
   task automatic pulse_reset();
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      check("async_rst_enable", u_if.Enable_SW_0, 1'b0);
      check("async_rst_press", u_if.Press, 1'b0);
      check("async_rst_release", u_if.Release, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", ecnt);
      $fatal(1, "timeout");
   end

   initial begin
      bit exp_tog[3];
      int base;
      int p0, r0;
      bit rmode;

      exp_tog = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 24; i++) begin
         tbl[i].raw   = (i + 1 <= 12);
         tbl[i].mode  = 1'b0;
         tbl[i].press = (i + 1 == LAT);
         tbl[i].rel   = (i + 1 == 12 + LAT);
         tbl[i].en    = (i + 1 >= LAT) && (i + 1 < 12 + LAT);
      end

      u_if.SW_raw = 1'b0;
      u_if.Toggle_Mode = 1'b0;
      hold_reset();

      // Clean rise and fall in level mode from the vector table.
      for (int i = 0; i < 24; i++) begin
         u_if.SW_raw = tbl[i].raw;
         u_if.Toggle_Mode = tbl[i].mode;
         @(posedge sysclk);
         ecnt++;
         model_edge(tbl[i].raw, tbl[i].mode);
         #1;
         check("tbl_press", u_if.Press, tbl[i].press);
         check("tbl_release", u_if.Release, tbl[i].rel);
         check("tbl_enable", u_if.Enable_SW_0, tbl[i].en);
         record_strobes();
      end

      // Bounce 1,0,1,0 with 3-cycle runs, then a stable rise.
      base = ecnt;
      p0 = n_press;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 3; k++) step(bit'(r % 2 == 0), 1'b0);
      check_int("bounce_no_early_press", n_press - p0, 0);
      for (int k = 0; k < 14; k++) step(1'b1, 1'b0);
      check_int("bounce_press_edge", last_press_edge, base + 13 + LAT - 1);
      check_int("bounce_press_count", n_press - p0, 1);
      for (int k = 0; k < 14; k++) step(1'b0, 1'b0);

      // Late bounce: 7 high, 1 low, then high; the count must restart.
      base = ecnt;
      p0 = n_press;
      for (int k = 0; k < 7; k++) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      for (int k = 0; k < 14; k++) step(1'b1, 1'b0);
      check_int("late_bounce_press_edge", last_press_edge, base + 9 + LAT - 1);
      check_int("late_bounce_press_count", n_press - p0, 1);
      for (int k = 0; k < 14; k++) step(1'b0, 1'b0);

      // Toggle mode: three press/release pairs from a fresh toggle flop.
      hold_reset();
      p0 = n_press;
      r0 = n_rel;
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 12; k++) step(1'b1, 1'b1);
         check("toggle_after_press", u_if.Enable_SW_0, exp_tog[p]);
         for (int k = 0; k < 12; k++) step(1'b0, 1'b1);
         check("toggle_after_release", u_if.Enable_SW_0, exp_tog[p]);
      end
      check_int("toggle_press_count", n_press - p0, 3);
      check_int("toggle_release_count", n_rel - r0, 3);

      // Mode switch with the switch released: enable drops next edge.
      p0 = n_press;
      r0 = n_rel;
      step(1'b0, 1'b0);
      check("mode_switch_enable", u_if.Enable_SW_0, 1'b0);
      check_int("mode_switch_strobes", (n_press - p0) + (n_rel - r0), 0);

      // Async reset mid-count with enable high in toggle mode.
      step(1'b0, 1'b1);
      check("pre_reset_enable", u_if.Enable_SW_0, 1'b1);
      p0 = n_press;
      for (int k = 0; k < 7; k++) step(1'b1, 1'b1);
      pulse_reset();
      check_int("reset_no_strobe", n_press - p0, 0);
      base = ecnt;
      for (int k = 0; k < 12; k++) step(1'b1, 1'b1);
      check_int("post_reset_press_edge", last_press_edge, base + LAT);
      check_int("post_reset_press_count", n_press - p0, 1);

      // Randomized switch activity with occasional mode flips and resets.
      rmode = 1'b0;
      while (ecnt < 3200) begin
         bit rv;
         int len;
         rv = bit'($urandom_range(0, 1));
         len = $urandom_range(1, 2 * DEB);
         if ($urandom_range(0, 7) == 0) rmode = !rmode;
         for (int k = 0; k < len; k++) step(rv, rmode);
         if ($urandom_range(0, 39) == 0) pulse_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
